// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, full-duty constant and register addresses common to the SPI block.
package pwm_pkg;
  localparam int NUM_CH = 16;
  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;
  typedef enum logic [7:0] {
    ADDR_EN_OUT_7_0  = 8'h00,
    ADDR_EN_OUT_15_8 = 8'h01,
    ADDR_EN_PWM_7_0  = 8'h02,
    ADDR_EN_PWM_15_8 = 8'h03,
    ADDR_PWM_DUTY    = 8'h04
  } reg_addr_e;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler, 8-bit PWM counter, period_start pulse and duty register.
// PWM_SHADOW_DUTY_EN: duty only reloads at the counter wrap, so mid-period writes cannot glitch.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] i_duty,
  output logic [DUTY_W-1:0] o_cnt,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_period_start
);
  localparam int PRE_W = $clog2(PRESCALE) + 1;
  logic [PRE_W-1:0]  r_pre;
  logic [DUTY_W-1:0] r_cnt;
  logic [DUTY_W-1:0] r_duty;
  logic              r_ps;
  logic              w_wrap;
  logic              w_roll;
  assign w_wrap = r_pre == PRE_W'(PRESCALE - 1);
  assign w_roll = w_wrap && (r_cnt == DUTY_FULL);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_duty <= '0;
      r_ps   <= 1'b0;
    end else begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap) r_cnt <= r_cnt + 1'b1;
      r_ps <= w_roll;
`ifdef PWM_SHADOW_DUTY_EN
      if (w_roll) r_duty <= i_duty;
`else
      r_duty <= i_duty;
`endif
    end
  end
  assign o_cnt          = r_cnt;
  assign o_duty         = r_duty;
  assign o_period_start = r_ps;
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 outputs, each forced low, static high or driven by the shared PWM level.
// Optional PWM_SHADOW_DUTY_EN (in pwm_timebase) makes duty updates period-aligned.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);
  logic [DUTY_W-1:0] w_cnt;
  logic [DUTY_W-1:0] w_duty;
  logic [NUM_CH-1:0] w_en_out;
  logic [NUM_CH-1:0] w_en_pwm;
  logic [NUM_CH-1:0] r_out;
  logic              w_hi;
  pwm_timebase #(.PRESCALE(PRESCALE)) u_tb (
    .clk           (clk),
    .rst           (rst),
    .i_duty        (pwm_duty_cycle),
    .o_cnt         (w_cnt),
    .o_duty        (w_duty),
    .o_period_start(period_start)
  );
  assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  // full duty is special-cased so 0xFF never shows the low count 255
  assign w_hi = (w_duty == DUTY_FULL) || (w_cnt < w_duty);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out <= '0;
    else     r_out <= w_en_out & (~w_en_pwm | {NUM_CH{w_hi}});
  end
  assign out = r_out;
endmodule
